// File: rtl/sa_feeder_pkg.sv
// Purpose: shared constants and types for the systolic-array edge feeder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sa_feeder_pkg;

    // Default A/B element width and array dimension (2x2 PEs)
    localparam int DW_DEF = 4;
    localparam int N      = 2;

    // Cycles from A accept edge to bottom-PE result valid, per column
    localparam int C0_LAT = 3;
    localparam int C1_LAT = 4;

    // In-flight tracker must cover the longest column latency
    localparam int INFL_W = C1_LAT;

    // Weight loader: row 1 word arrives first, then row 0 completes the set
    typedef enum logic {
        W_ROW1 = 1'b0,
        W_ROW0 = 1'b1
    } wstate_t;

endpackage

// File: rtl/sa_skew_line.sv
// Purpose: per-row A skew registers (row1 one cycle behind row0) plus in-flight valid shift.
// Latency: row0 lane 1 cycle, row1 lane 2 cycles; in-flight bit k set k+1 cycles after accept.
// Backpressure: none; accepts whenever i_accept is high, non-accepted cycles inject zero bubbles.
module sa_skew_line
    import sa_feeder_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_accept,
    input  logic [N*DW-1:0]   i_a_data,
    output logic [N*DW-1:0]   o_a_left,
    output logic [INFL_W-1:0] o_inflight
);

    logic [DW-1:0]     r_row0;
    logic [DW-1:0]     r_row1_dly;
    logic [DW-1:0]     r_row1;
    logic [INFL_W-1:0] r_inflight;

    // Skew the A lanes and track which cycles carry a real vector; bubbles are zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row0     <= '0;
            r_row1_dly <= '0;
            r_row1     <= '0;
            r_inflight <= '0;
        end else begin
            r_row0     <= i_accept ? i_a_data[DW-1:0] : '0;
            r_row1_dly <= i_accept ? i_a_data[N*DW-1:DW] : '0;
            r_row1     <= r_row1_dly;
            r_inflight <= {r_inflight[INFL_W-2:0], i_accept};
        end
    end

    assign o_a_left   = {r_row1, r_row0};
    assign o_inflight = r_inflight;

endmodule

// File: rtl/sa_feeder.sv
// Purpose: feeds a 2x2 weight-stationary systolic array: double-buffered weight load, skewed A, result valids.
// Latency: A accept -> a_left row0 +1, row1 +2; c_valid col0 +3, col1 +4; swap 1 cycle after drain.
// Backpressure: w_ready drops while a full weight set awaits swap; a_ready low until active set and while pending.
module sa_feeder
    import sa_feeder_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            w_valid,
    output logic            w_ready,
    input  logic [N*DW-1:0] w_data,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [N*DW-1:0] a_data,
    output logic [N*DW-1:0] b_top,
    output logic [N*DW-1:0] a_left,
    output logic            load_w,
    output logic            sel_w_load,
    output logic            sel_w_active,
    output logic            compute_en,
    output logic            clear_psum,
    output logic [N-1:0]    c_valid
);

    wstate_t           r_state;
    wstate_t           w_nstate;
    logic [N*DW-1:0]   r_b_top;
    logic              r_load_w;
    logic              r_sel_active;
    logic              r_sel_load;
    logic              r_pending;
    logic              r_active_valid;
    logic              r_clear_psum;

    logic              w_w_hs;
    logic              w_set_done;
    logic              w_a_accept;
    logic              w_swap;
    logic [INFL_W-1:0] w_inflight;

    // Weight loader state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= W_ROW1;
        else        r_state <= w_nstate;
    end

    // Weight loader next state and w_ready; a new set may only start once the previous one is swapped in
    always_comb begin
        w_nstate = r_state;
        w_ready  = 1'b0;
        case (r_state)
            W_ROW1: begin
                w_ready = !r_pending;
                if (w_valid && !r_pending) w_nstate = W_ROW0;
            end
            W_ROW0: begin
                w_ready = 1'b1;
                if (w_valid) w_nstate = W_ROW1;
            end
            default: w_nstate = W_ROW1;
        endcase
    end

    assign w_w_hs     = w_valid && w_ready;
    assign w_set_done = w_w_hs && (r_state == W_ROW0);

    // No vector may straddle a bank swap, so accepts stop as soon as a new set is pending
    assign a_ready    = r_active_valid && !r_pending;
    assign w_a_accept = a_valid && a_ready;

    // Swap only once every in-flight vector has left the array
    assign w_swap = r_pending && (w_inflight == '0) && !w_a_accept;

    // Weight datapath, bank select and swap bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_top        <= '0;
            r_load_w       <= 1'b0;
            r_sel_active   <= 1'b0;
            r_sel_load     <= 1'b1;
            r_pending      <= 1'b0;
            r_active_valid <= 1'b0;
            r_clear_psum   <= 1'b0;
        end else begin
            if (w_w_hs) r_b_top <= w_data;
            r_load_w     <= w_set_done;
            r_clear_psum <= w_swap;
            if (w_set_done) begin
                r_pending <= 1'b1;
            end else if (w_swap) begin
                r_pending      <= 1'b0;
                r_sel_active   <= !r_sel_active;
                r_sel_load     <= r_sel_active;
                r_active_valid <= 1'b1;
            end
        end
    end

    sa_skew_line #(
        .DW (DW)
    ) u_skew (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_accept   (w_a_accept),
        .i_a_data   (a_data),
        .o_a_left   (a_left),
        .o_inflight (w_inflight)
    );

    assign b_top        = r_b_top;
    assign load_w       = r_load_w;
    assign sel_w_active = r_sel_active;
    assign sel_w_load   = r_sel_load;
    assign clear_psum   = r_clear_psum;
    assign compute_en   = r_active_valid;
    assign c_valid      = {w_inflight[C1_LAT-1], w_inflight[C0_LAT-1]};

endmodule

// File: tb/tb_sa_feeder.sv
// Purpose: directed self-checking bench for sa_feeder (weight load, skew, streaming, reload, reset).
// Latency: n/a.
// Backpressure: exercises w_ready blocking while pending and a_ready drop across a swap.
module tb_sa_feeder;

    logic       clk;
    logic       rst_n;
    logic       w_valid;
    logic       w_ready;
    logic [7:0] w_data;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] a_data;
    logic [7:0] b_top;
    logic [7:0] a_left;
    logic       load_w;
    logic       sel_w_load;
    logic       sel_w_active;
    logic       compute_en;
    logic       clear_psum;
    logic [1:0] c_valid;

    int n_cmp;
    int n_fail;

    sa_feeder #(.DW(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_data       (a_data),
        .b_top        (b_top),
        .a_left       (a_left),
        .load_w       (load_w),
        .sel_w_load   (sel_w_load),
        .sel_w_active (sel_w_active),
        .compute_en   (compute_en),
        .clear_psum   (clear_psum),
        .c_valid      (c_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst_n = 1'b0; w_valid = 1'b0; w_data = 8'h00; a_valid = 1'b0; a_data = 8'h00;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (b_top !== 8'h00)      begin n_fail++; $display("FAIL rst_b_top got %h want 00", b_top); end
        n_cmp++; if (a_left !== 8'h00)     begin n_fail++; $display("FAIL rst_a_left got %h want 00", a_left); end
        n_cmp++; if (load_w !== 1'b0)      begin n_fail++; $display("FAIL rst_load_w got %b want 0", load_w); end
        n_cmp++; if (sel_w_active !== 1'b0) begin n_fail++; $display("FAIL rst_sel_act got %b want 0", sel_w_active); end
        n_cmp++; if (sel_w_load !== 1'b1)  begin n_fail++; $display("FAIL rst_sel_load got %b want 1", sel_w_load); end
        n_cmp++; if (clear_psum !== 1'b0)  begin n_fail++; $display("FAIL rst_clear got %b want 0", clear_psum); end
        n_cmp++; if (c_valid !== 2'b00)    begin n_fail++; $display("FAIL rst_c_valid got %b want 00", c_valid); end
        n_cmp++; if (a_ready !== 1'b0)     begin n_fail++; $display("FAIL rst_a_ready got %b want 0", a_ready); end
        n_cmp++; if (compute_en !== 1'b0)  begin n_fail++; $display("FAIL rst_compute got %b want 0", compute_en); end
        n_cmp++; if (w_ready !== 1'b1)     begin n_fail++; $display("FAIL rst_w_ready got %b want 1", w_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_weight_load();
        w_valid = 1'b1; w_data = 8'h21;
        n_cmp++; if (w_ready !== 1'b1) begin n_fail++; $display("FAIL wl_ready1 got %b want 1", w_ready); end
        @(negedge clk);
        w_valid = 1'b0;
        n_cmp++; if (b_top !== 8'h21)  begin n_fail++; $display("FAIL wl_btop1 got %h want 21", b_top); end
        n_cmp++; if (load_w !== 1'b0)  begin n_fail++; $display("FAIL wl_load_early got %b want 0", load_w); end
        @(negedge clk); @(negedge clk);
        n_cmp++; if (b_top !== 8'h21)  begin n_fail++; $display("FAIL wl_btop_hold got %h want 21", b_top); end
        n_cmp++; if (w_ready !== 1'b1) begin n_fail++; $display("FAIL wl_ready0 got %b want 1", w_ready); end
        w_valid = 1'b1; w_data = 8'h43;
        @(negedge clk);
        w_valid = 1'b0;
        n_cmp++; if (load_w !== 1'b1)  begin n_fail++; $display("FAIL wl_load_pulse got %b want 1", load_w); end
        n_cmp++; if (b_top !== 8'h43)  begin n_fail++; $display("FAIL wl_btop2 got %h want 43", b_top); end
        n_cmp++; if (sel_w_active !== 1'b0) begin n_fail++; $display("FAIL wl_sel_pre got %b want 0", sel_w_active); end
        n_cmp++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL wl_ready_pend got %b want 0", w_ready); end
        n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL wl_a_ready_pend got %b want 0", a_ready); end
        @(negedge clk);
        n_cmp++; if (sel_w_active !== 1'b1) begin n_fail++; $display("FAIL wl_sel_post got %b want 1", sel_w_active); end
        n_cmp++; if (sel_w_load !== 1'b0) begin n_fail++; $display("FAIL wl_sel_load got %b want 0", sel_w_load); end
        n_cmp++; if (clear_psum !== 1'b1) begin n_fail++; $display("FAIL wl_clear got %b want 1", clear_psum); end
        n_cmp++; if (load_w !== 1'b0)  begin n_fail++; $display("FAIL wl_load_once got %b want 0", load_w); end
        n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL wl_a_ready got %b want 1", a_ready); end
        n_cmp++; if (compute_en !== 1'b1) begin n_fail++; $display("FAIL wl_compute got %b want 1", compute_en); end
        @(negedge clk);
        n_cmp++; if (clear_psum !== 1'b0) begin n_fail++; $display("FAIL wl_clear_once got %b want 0", clear_psum); end
    endtask

    task automatic test_single_vector();
        a_valid = 1'b1; a_data = 8'h32;
        n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL sv_ready got %b want 1", a_ready); end
        @(negedge clk);
        a_valid = 1'b0;
        n_cmp++; if (a_left !== 8'h02)  begin n_fail++; $display("FAIL sv_aleft_t1 got %h want 02", a_left); end
        n_cmp++; if (c_valid !== 2'b00) begin n_fail++; $display("FAIL sv_cv_t1 got %b want 00", c_valid); end
        @(negedge clk);
        n_cmp++; if (a_left !== 8'h30)  begin n_fail++; $display("FAIL sv_aleft_t2 got %h want 30", a_left); end
        n_cmp++; if (c_valid !== 2'b00) begin n_fail++; $display("FAIL sv_cv_t2 got %b want 00", c_valid); end
        @(negedge clk);
        n_cmp++; if (c_valid !== 2'b01) begin n_fail++; $display("FAIL sv_cv_t3 got %b want 01", c_valid); end
        n_cmp++; if (a_left !== 8'h00)  begin n_fail++; $display("FAIL sv_aleft_t3 got %h want 00", a_left); end
        @(negedge clk);
        n_cmp++; if (c_valid !== 2'b10) begin n_fail++; $display("FAIL sv_cv_t4 got %b want 10", c_valid); end
        @(negedge clk);
        n_cmp++; if (c_valid !== 2'b00) begin n_fail++; $display("FAIL sv_cv_t5 got %b want 00", c_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec [4];
        logic [7:0] exp_left;
        logic [1:0] exp_cv;
        vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33; vec[3] = 8'h44;
        for (int k = 0; k < 9; k++) begin
            a_valid = (k < 4);
            a_data  = (k < 4) ? vec[k] : 8'h00;
            if (k < 4) begin
                n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready k=%0d got %b want 1", k, a_ready); end
            end
            @(negedge clk);
            // m = k+1 is the cycle index counted from the first accept edge
            exp_left[3:0] = (k + 1 <= 4) ? vec[k][3:0] : 4'h0;
            exp_left[7:4] = (k >= 1 && k <= 4) ? vec[k-1][7:4] : 4'h0;
            exp_cv[0] = (k + 1 >= 3) && (k + 1 <= 6);
            exp_cv[1] = (k + 1 >= 4) && (k + 1 <= 7);
            n_cmp++; if (a_left !== exp_left) begin n_fail++; $display("FAIL b2b_aleft m=%0d got %h want %h", k + 1, a_left, exp_left); end
            n_cmp++; if (c_valid !== exp_cv)  begin n_fail++; $display("FAIL b2b_cv m=%0d got %b want %b", k + 1, c_valid, exp_cv); end
        end
        a_valid = 1'b0;
    endtask

    task automatic test_reload_during_stream();
        for (int k = 0; k < 7; k++) begin
            a_valid = 1'b1;
            a_data  = (k == 0) ? 8'h11 : (k == 1) ? 8'h22 : 8'h33;
            w_valid = (k < 2);
            w_data  = (k == 0) ? 8'h65 : 8'h87;
            @(negedge clk);
            if (k + 1 == 2) begin
                n_cmp++; if (load_w !== 1'b1) begin n_fail++; $display("FAIL rl_load got %b want 1", load_w); end
                n_cmp++; if (b_top !== 8'h87) begin n_fail++; $display("FAIL rl_btop got %h want 87", b_top); end
            end
            if (k + 1 >= 2 && k + 1 <= 6) begin
                n_cmp++; if (sel_w_active !== 1'b1) begin n_fail++; $display("FAIL rl_sel_hold m=%0d got %b want 1", k + 1, sel_w_active); end
                n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL rl_a_ready_pend m=%0d got %b want 0", k + 1, a_ready); end
            end
        end
        w_valid = 1'b0;
        n_cmp++; if (sel_w_active !== 1'b0) begin n_fail++; $display("FAIL rl_sel_swap got %b want 0", sel_w_active); end
        n_cmp++; if (clear_psum !== 1'b1)   begin n_fail++; $display("FAIL rl_clear got %b want 1", clear_psum); end
        n_cmp++; if (a_ready !== 1'b1)      begin n_fail++; $display("FAIL rl_a_ready_back got %b want 1", a_ready); end
        @(negedge clk);
        a_valid = 1'b0;
        for (int k = 0; k < 6; k++) @(negedge clk);
    endtask

    task automatic test_blocked_third();
        for (int k = 0; k < 7; k++) begin
            a_valid = (k == 0);
            a_data  = 8'h11;
            w_valid = 1'b1;
            w_data  = (k == 0) ? 8'hA9 : (k == 1) ? 8'hCB : 8'hED;
            if (k >= 2 && k <= 5) begin
                n_cmp++; if (w_ready !== 1'b0) begin n_fail++; $display("FAIL bt_w_ready_blk m=%0d got %b want 0", k, w_ready); end
            end
            if (k == 6) begin
                n_cmp++; if (w_ready !== 1'b1) begin n_fail++; $display("FAIL bt_w_ready_free got %b want 1", w_ready); end
            end
            @(negedge clk);
            if (k + 1 == 2) begin
                n_cmp++; if (load_w !== 1'b1) begin n_fail++; $display("FAIL bt_load got %b want 1", load_w); end
            end
            if (k + 1 >= 3 && k + 1 <= 6) begin
                n_cmp++; if (load_w !== 1'b0) begin n_fail++; $display("FAIL bt_no_load m=%0d got %b want 0", k + 1, load_w); end
                n_cmp++; if (b_top !== 8'hCB) begin n_fail++; $display("FAIL bt_btop_hold m=%0d got %h want cb", k + 1, b_top); end
            end
            if (k + 1 == 6) begin
                n_cmp++; if (clear_psum !== 1'b1)   begin n_fail++; $display("FAIL bt_clear got %b want 1", clear_psum); end
                n_cmp++; if (sel_w_active !== 1'b1) begin n_fail++; $display("FAIL bt_sel got %b want 1", sel_w_active); end
            end
        end
        w_valid = 1'b0;
        n_cmp++; if (b_top !== 8'hED)  begin n_fail++; $display("FAIL bt_btop_third got %h want ed", b_top); end
        n_cmp++; if (load_w !== 1'b0)  begin n_fail++; $display("FAIL bt_load_third got %b want 0", load_w); end
    endtask

    task automatic test_reset_midflight();
        n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rm_a_ready got %b want 1", a_ready); end
        a_valid = 1'b1; a_data = 8'h55;
        @(negedge clk);
        a_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (b_top !== 8'h00)      begin n_fail++; $display("FAIL rm_btop got %h want 00", b_top); end
        n_cmp++; if (a_left !== 8'h00)     begin n_fail++; $display("FAIL rm_aleft got %h want 00", a_left); end
        n_cmp++; if (sel_w_active !== 1'b0) begin n_fail++; $display("FAIL rm_sel got %b want 0", sel_w_active); end
        n_cmp++; if (sel_w_load !== 1'b1)  begin n_fail++; $display("FAIL rm_sel_load got %b want 1", sel_w_load); end
        n_cmp++; if (compute_en !== 1'b0)  begin n_fail++; $display("FAIL rm_compute got %b want 0", compute_en); end
        n_cmp++; if (a_ready !== 1'b0)     begin n_fail++; $display("FAIL rm_a_ready got %b want 0", a_ready); end
        n_cmp++; if (w_ready !== 1'b1)     begin n_fail++; $display("FAIL rm_w_ready got %b want 1", w_ready); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++; if (c_valid !== 2'b00) begin n_fail++; $display("FAIL rm_stray_cv k=%0d got %b want 00", k, c_valid); end
            n_cmp++; if (load_w !== 1'b0)   begin n_fail++; $display("FAIL rm_stray_load k=%0d got %b want 0", k, load_w); end
            n_cmp++; if (a_left !== 8'h00)  begin n_fail++; $display("FAIL rm_stray_aleft k=%0d got %h want 00", k, a_left); end
        end
        w_valid = 1'b1; w_data = 8'h12;
        @(negedge clk);
        n_cmp++; if (load_w !== 1'b0) begin n_fail++; $display("FAIL rm_fsm_row1 got %b want 0", load_w); end
        n_cmp++; if (b_top !== 8'h12) begin n_fail++; $display("FAIL rm_btop1 got %h want 12", b_top); end
        w_data = 8'h34;
        @(negedge clk);
        w_valid = 1'b0;
        n_cmp++; if (load_w !== 1'b1) begin n_fail++; $display("FAIL rm_fsm_row0 got %b want 1", load_w); end
        n_cmp++; if (b_top !== 8'h34) begin n_fail++; $display("FAIL rm_btop2 got %h want 34", b_top); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_weight_load();
        test_single_vector();
        test_back_to_back();
        test_reload_during_stream();
        test_blocked_third();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_feeder.md
SA_FEEDER -- requirements
Module: sa_feeder

Interface
REQ-001 SHALL have parameter DW, default 4, meaning A/B element width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port w_valid  input  1  weight word offered.
REQ-005 SHALL have port w_ready  output  1  weight word accepted when w_valid&&w_ready.
REQ-006 SHALL have port w_data  input  2*DW  one weight row: {col1, col0}.
REQ-007 SHALL have port a_valid  input  1  A vector offered.
REQ-008 SHALL have port a_ready  output  1  A vector accepted when a_valid&&a_ready.
REQ-009 SHALL have port a_data  input  2*DW  {a1 (array row 1), a0 (array row 0)}.
REQ-010 SHALL have port b_top  output  2*DW  to top-row PE b_in: {col1, col0}.
REQ-011 SHALL have port a_left  output  2*DW  to left-column PE a_in: {row1, row0}.
REQ-012 SHALL have port load_w  output  1  to all PEs, capture b_in into load bank.
REQ-013 SHALL have port sel_w_load  output  1  to all PEs, bank being loaded.
REQ-014 SHALL have port sel_w_active  output  1  to all PEs, bank used for MAC.
REQ-015 SHALL have port compute_en  output  1  to all PEs, MAC enable.
REQ-016 SHALL have port clear_psum  output  1  to all PEs, psum clear.
REQ-017 SHALL have port c_valid  output  2  bit c high: bottom PE of column c holds a valid result.

Function
REQ-018 All outputs SHALL be registered, except w_ready, a_ready and compute_en, which are combinational from registers.
REQ-019 Weight loader SHALL be an FSM with states W_ROW1 and W_ROW0.
REQ-020 The first accepted word SHALL be PE row 1's weights, the second PE row 0's weights.
REQ-021 W_ROW1: w_ready = !pending; on handshake, b_top <= w_data next cycle and go to W_ROW0.
REQ-022 W_ROW0: w_ready = 1; on handshake, b_top <= w_data and load_w <= 1 for exactly one cycle, set pending, and go to W_ROW1.
REQ-023 b_top SHALL hold its last value between handshakes, so arbitrary gaps between the two words load correctly.
REQ-024 sel_w_load SHALL equal !sel_w_active at all times.
REQ-025 Swap: when pending=1 and the pipeline is empty (no in-flight bits and no accept this cycle), the next edge SHALL:
- toggle sel_w_active;
- clear pending;
- set active_valid;
- pulse clear_psum for one cycle.
REQ-026 a_ready SHALL be active_valid && !pending, so no vector ever straddles a bank swap.
REQ-027 On A accept at edge t:
- a_left[row0] = a0 during cycle t+1;
- a_left[row1] = a1 during cycle t+2 (one-cycle skew);
- otherwise the respective lane SHALL be 0.
REQ-028 c_valid[0] SHALL be high in cycle t+3 and c_valid[1] in cycle t+4, via a 4-bit in-flight shift register.
REQ-029 Back-to-back accepts SHALL give a throughput of one vector per cycle with no bubbles.
REQ-030 compute_en SHALL equal active_valid; bubble lanes carry zero, so products are zero.
REQ-031 Loading the shadow bank during compute SHALL be permitted; only the second full set blocks, via w_ready=0 while pending.
REQ-032 Simultaneous w handshake in W_ROW0 and a swap condition SHALL NOT occur, because pending=0 is required in W_ROW0's predecessor and pending is only set by W_ROW0.

Reset
REQ-033 rst_n low SHALL asynchronously force:
- b_top=0, a_left=0, load_w=0, clear_psum=0, c_valid=0;
- sel_w_active=0, pending=0, active_valid=0, in-flight bits=0;
- FSM=W_ROW1.
REQ-034 Reset mid-load or mid-compute SHALL discard partial weight sets and in-flight vectors, with no c_valid pulse after release.
REQ-035 After reset, a_ready SHALL stay 0 until the first weight set has been swapped active.

Structure
REQ-036 A shared package SHALL hold DW, the array dimension N=2, the FSM state encoding and the c_valid latency constants (3, 4).
REQ-037 One sub-module, sa_skew_line (per-row delay registers plus valid shift), is natural; everything else SHALL be inline.

Verification
REQ-038 Reset, then weights 0x21 (row1) and 0x43 (row0):
- load_w pulses once, with b_top=0x43 in that cycle;
- sel_w_active goes 0->1;
- a_ready rises.
REQ-039 With weights active, accept a_data=0x32:
- a_left=0x02 at t+1 and 0x30 at t+2;
- c_valid=01 at t+3 and 10 at t+4.
REQ-040 Four back-to-back vectors: c_valid[0] high for four consecutive cycles with no gaps; a_ready stays 1.
REQ-041 Load a second weight set while vectors stream:
- sel_w_active stays fixed until in-flight drains;
- a_ready=0 while pending;
- then swap and clear_psum pulse.
REQ-042 Third weight set offered while pending: w_ready=0 until swap completes, with no load_w pulse.
REQ-043 Assert rst_n low between the two weight words and with a vector in flight: all outputs return to reset values, and no stray c_valid or load_w appears.
